// File: rtl/alu_dispatch.sv
// RV32I decode-and-dispatch stage: decodes ALU/branch instructions into operands and an
// op code, then hands them to the ALU through a 2-entry flushable buffer.
module alu_dispatch #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] a_o,
   output logic [31:0] b_o,
   output logic [3:0]  alu_op_o,
   output logic        is_branch_o,
   output logic [2:0]  funct3_o,
   output logic        illegal_o
);
   localparam logic [3:0] OP_SLL  = 4'd0;
   localparam logic [3:0] OP_SRA  = 4'd1;
   localparam logic [3:0] OP_SRL  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_XOR  = 4'd9;
   localparam logic [3:0] OP_SLT  = 4'd11;
   localparam logic [3:0] OP_SLTU = 4'd12;
   localparam logic [3:0] OP_NOP  = 4'd15;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic        br;
      logic [2:0]  f3;
      logic        ill;
   } entry_t;

   entry_t      dec;
   entry_t      head;
   entry_t      mem_q [DEPTH];
   logic        rptr_q, rptr_d;
   logic        wptr_q, wptr_d;
   logic [1:0]  count_q, count_d;
   logic        push, pop;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [3:0]  op_f3;
   logic [31:0] imm_i, imm_u, shamt;
   logic        unused_rd;

   assign opcode    = instr_i[6:0];
   assign f3        = instr_i[14:12];
   assign f7        = instr_i[31:25];
   assign imm_i     = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_u     = {instr_i[31:12], 12'b0};
   assign shamt     = {27'b0, instr_i[24:20]};
   assign unused_rd = ^instr_i[11:7];

   // funct3 mapping shared by OP and OP-IMM; shift forms are refined below.
   always_comb begin
      case (f3)
         3'd0:    op_f3 = OP_ADD;
         3'd1:    op_f3 = OP_SLL;
         3'd2:    op_f3 = OP_SLT;
         3'd3:    op_f3 = OP_SLTU;
         3'd4:    op_f3 = OP_XOR;
         3'd5:    op_f3 = OP_SRL;
         3'd6:    op_f3 = OP_OR;
         default: op_f3 = OP_AND;
      endcase
   end

   always_comb begin
      dec     = '0;
      dec.f3  = f3;
      dec.op  = OP_NOP;
      case (opcode)
         OPC_OP: begin
            dec.a = rs1_i;
            dec.b = rs2_i;
            if (f7 == 7'b0000000)                    dec.op = op_f3;
            else if (f7 == 7'b0100000 && f3 == 3'd0) dec.op = OP_SUB;
            else if (f7 == 7'b0100000 && f3 == 3'd5) dec.op = OP_SRA;
            else                                     dec.ill = 1'b1;
         end
         OPC_OPIMM: begin
            dec.a = rs1_i;
            if (f3 == 3'd1) begin
               dec.b   = shamt;
               dec.op  = OP_SLL;
               dec.ill = (f7 != 7'b0000000);
            end else if (f3 == 3'd5) begin
               dec.b = shamt;
               if (f7 == 7'b0000000)      dec.op = OP_SRL;
               else if (f7 == 7'b0100000) dec.op = OP_SRA;
               else                       dec.ill = 1'b1;
            end else begin
               dec.b  = imm_i;
               dec.op = op_f3;
            end
         end
         OPC_LUI: begin
            dec.b  = imm_u;
            dec.op = OP_ADD;
         end
         OPC_AUIPC: begin
            dec.a  = pc_i;
            dec.b  = imm_u;
            dec.op = OP_ADD;
         end
         OPC_BRANCH: begin
            dec.a   = rs1_i;
            dec.b   = rs2_i;
            dec.op  = OP_SUB;
            dec.br  = 1'b1;
            dec.ill = (f3 == 3'd2) || (f3 == 3'd3);
         end
         default: dec.ill = 1'b1;
      endcase
      // Illegal encodings still travel down the pipe, but as an inert NOP.
      if (dec.ill) begin
         dec.a  = '0;
         dec.b  = '0;
         dec.op = OP_NOP;
         dec.br = 1'b0;
      end
   end

   assign in_ready_o  = (count_q != 2'(DEPTH));
   assign out_valid_o = (count_q != 2'd0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush_i) begin
         rptr_d  = 1'b0;
         wptr_d  = 1'b0;
         count_d = 2'd0;
      end else begin
         if (push) wptr_d = ~wptr_q;
         if (pop)  rptr_d = ~rptr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr_q  <= 1'b0;
         wptr_q  <= 1'b0;
         count_q <= 2'd0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         if (push && !flush_i) mem_q[wptr_q] <= dec;
      end
   end

   assign head        = mem_q[rptr_q];
   assign a_o         = head.a;
   assign b_o         = head.b;
   assign alu_op_o    = head.op;
   assign is_branch_o = head.br;
   assign funct3_o    = head.f3;
   assign illegal_o   = head.ill;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: directed scenarios plus a randomized stream checked against
// a queue-based reference of the decode rules and the 2-deep buffer.
module tb_alu_dispatch;
   localparam int W = 73;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
   logic [31:0] instr_i, pc_i, rs1_i, rs2_i, a_o, b_o;
   logic [3:0]  alu_op_o;
   logic        is_branch_o, illegal_o;
   logic [2:0]  funct3_o;
   logic [W-1:0] got;
   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad = 0;

   localparam logic [3:0] F3_OP [8] = '{4'd5, 4'd0, 4'd11, 4'd12, 4'd9, 4'd2, 4'd8, 4'd7};

   alu_dispatch #(.DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .a_o(a_o), .b_o(b_o), .alu_op_o(alu_op_o), .is_branch_o(is_branch_o),
      .funct3_o(funct3_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   assign got = {a_o, b_o, alu_op_o, is_branch_o, funct3_o, illegal_o};

   // Reference decode: {a, b, op, is_branch, funct3, illegal}
   function automatic logic [W-1:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                               input logic [31:0] r1, input logic [31:0] r2);
      logic [31:0] a, b;
      logic [3:0]  op;
      logic        br, ill;
      int          fn3, fn7;
      fn3 = int'(ins[14:12]);
      fn7 = int'(ins[31:25]);
      a = 0; b = 0; op = 4'd15; br = 0; ill = 0;
      if (ins[6:0] == 7'h33) begin
         a = r1; b = r2;
         if (fn7 == 0) op = F3_OP[fn3];
         else if (fn7 == 32 && fn3 == 0) op = 4'd6;
         else if (fn7 == 32 && fn3 == 5) op = 4'd1;
         else ill = 1;
      end else if (ins[6:0] == 7'h13) begin
         a = r1;
         b = 32'($signed(ins[31:20]));
         op = F3_OP[fn3];
         if (fn3 == 1 || fn3 == 5) b = 32'(ins[24:20]);
         if (fn3 == 1 && fn7 != 0) ill = 1;
         if (fn3 == 5 && fn7 == 32) op = 4'd1;
         else if (fn3 == 5 && fn7 != 0) ill = 1;
      end else if (ins[6:0] == 7'h37) begin
         b = ins & 32'hFFFFF000; op = 4'd5;
      end else if (ins[6:0] == 7'h17) begin
         a = pc; b = ins & 32'hFFFFF000; op = 4'd5;
      end else if (ins[6:0] == 7'h63) begin
         a = r1; b = r2; op = 4'd6; br = 1;
         ill = (fn3 == 2 || fn3 == 3);
      end else begin
         ill = 1;
      end
      if (ill) begin a = 0; b = 0; op = 4'd15; br = 0; end
      return {a, b, op, br, ins[14:12], ill};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 7))
         0, 1:    w[6:0] = 7'h33;
         2, 3:    w[6:0] = 7'h13;
         4:       w[6:0] = 7'h37;
         5:       w[6:0] = 7'h17;
         6:       w[6:0] = 7'h63;
         default: w[6:0] = w[6:0];
      endcase
      if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
      return w;
   endfunction

   // Drives one cycle from a negedge and advances the reference buffer at the posedge.
   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic rdy, input logic fl);
      logic accept, take;
      in_valid_i = v; instr_i = ins; rs1_i = r1; rs2_i = r2;
      pc_i = $urandom(); out_ready_i = rdy; flush_i = fl;
      accept = v && (exp_q.size() != 2);
      take   = rdy && (exp_q.size() != 0);
      @(posedge clk);
      if (fl) exp_q.delete();
      else begin
         if (take) void'(exp_q.pop_front());
         if (accept) exp_q.push_back(ref_decode(ins, pc_i, r1, r2));
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
   endtask

   task automatic test_reset();
      in_valid_i = 0; instr_i = 0; pc_i = 0; rs1_i = 0; rs2_i = 0;
      out_ready_i = 0; flush_i = 0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
      total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
      total++; if (got !== '0) begin bad++; $display("FAIL reset_fields got=%h exp=0", got); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
         bad++; $display("FAIL post_reset_flags got=%b%b exp=01", out_valid_o, in_ready_o); end
   endtask

   task automatic test_single_add();
      drive(1'b1, 32'h003100B3, 32'd7, 32'd5, 1'b0, 1'b0);
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid_o); end
      total++; if ({a_o, b_o, alu_op_o, illegal_o} !== {32'd7, 32'd5, 4'd5, 1'b0}) begin
         bad++; $display("FAIL add_fields got=%h/%h/%0d/%b exp=7/5/5/0", a_o, b_o, alu_op_o, illegal_o); end
      idle(1'b1);
   endtask

   task automatic test_immediates();
      logic [31:0] ins [3];
      logic [31:0] eb  [3];
      logic [3:0]  eop [3];
      ins = '{32'h4041D093, 32'hFFF00093, 32'h123450B7};
      eb  = '{32'd4, 32'hFFFFFFFF, 32'h12345000};
      eop = '{4'd1, 4'd5, 4'd5};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ins[i], 32'h80000000, 32'h1234, 1'b0, 1'b0);
         total++; if (b_o !== eb[i] || alu_op_o !== eop[i] || out_valid_o !== 1'b1) begin
            bad++; $display("FAIL imm_%0d got=b:%h op:%0d v:%b exp=b:%h op:%0d v:1", i, b_o, alu_op_o, out_valid_o, eb[i], eop[i]); end
         total++; if (got !== exp_q[0]) begin bad++; $display("FAIL imm_model_%0d got=%h exp=%h", i, got, exp_q[0]); end
         if (i == 2) begin
            total++; if (a_o !== 32'h0) begin bad++; $display("FAIL lui_a got=%h exp=0", a_o); end
         end
         idle(1'b1);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] held;
      drive(1'b1, 32'h003100B3, 32'd1, 32'd10, 1'b0, 1'b0);
      drive(1'b1, 32'h003100B3, 32'd2, 32'd20, 1'b0, 1'b0);
      total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready_o); end
      held = got;
      drive(1'b1, 32'h003100B3, 32'd3, 32'd30, 1'b0, 1'b0);
      total++; if (got !== held || a_o !== 32'd1) begin bad++; $display("FAIL bp_stable got=%h exp=%h", got, held); end
      total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_before_pop got=%b exp=0", in_ready_o); end
      drive(1'b1, 32'h003100B3, 32'd3, 32'd30, 1'b1, 1'b0);
      total++; if (in_ready_o !== 1'b1 || a_o !== 32'd2) begin
         bad++; $display("FAIL bp_first_pop got=rdy:%b a:%0d exp=rdy:1 a:2", in_ready_o, a_o); end
      drive(1'b1, 32'h003100B3, 32'd3, 32'd30, 1'b1, 1'b0);
      total++; if (a_o !== 32'd3 || out_valid_o !== 1'b1) begin
         bad++; $display("FAIL bp_third got=a:%0d v:%b exp=a:3 v:1", a_o, out_valid_o); end
      idle(1'b1);
      total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid_o); end
   endtask

   task automatic test_branch_illegal();
      drive(1'b1, 32'h00208463, 32'd9, 32'd9, 1'b0, 1'b0);
      total++; if ({is_branch_o, funct3_o, alu_op_o, illegal_o} !== {1'b1, 3'd0, 4'd6, 1'b0}) begin
         bad++; $display("FAIL beq got=br:%b f3:%0d op:%0d ill:%b exp=1/0/6/0", is_branch_o, funct3_o, alu_op_o, illegal_o); end
      idle(1'b1);
      drive(1'b1, 32'h0020A463, 32'd9, 32'd9, 1'b0, 1'b0);
      total++; if ({illegal_o, alu_op_o, is_branch_o} !== {1'b1, 4'd15, 1'b0}) begin
         bad++; $display("FAIL br_f3_010 got=ill:%b op:%0d br:%b exp=1/15/0", illegal_o, alu_op_o, is_branch_o); end
      idle(1'b1);
      drive(1'b1, 32'h00000073, 32'd9, 32'd9, 1'b0, 1'b0);
      total++; if ({illegal_o, a_o, b_o, alu_op_o} !== {1'b1, 32'd0, 32'd0, 4'd15}) begin
         bad++; $display("FAIL opc_73 got=ill:%b a:%h b:%h op:%0d exp=1/0/0/15", illegal_o, a_o, b_o, alu_op_o); end
      idle(1'b1);
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h003100B3, 32'd1, 32'd1, 1'b0, 1'b0);
      drive(1'b1, 32'h003100B3, 32'd2, 32'd2, 1'b0, 1'b0);
      drive(1'b1, 32'h003100B3, 32'd3, 32'd3, 1'b1, 1'b1);
      total++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
         bad++; $display("FAIL flush_flags got=v:%b r:%b exp=v:0 r:1", out_valid_o, in_ready_o); end
      idle(1'b1);
      idle(1'b1);
      total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", out_valid_o); end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 32'h003100B3, 32'd100, 32'd1, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         total++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1 || got !== exp_q[0]) begin
            bad++; $display("FAIL b2b_%0d got=v:%b r:%b %h exp=v:1 r:1 %h", k, out_valid_o, in_ready_o, got, exp_q[0]); end
         drive(1'b1, 32'h003100B3, 32'(101 + k), 32'd1, 1'b1, 1'b0);
      end
      total++; if (a_o !== 32'd106) begin bad++; $display("FAIL b2b_last got=%0d exp=106", a_o); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid_o !== 1'b0 || got !== '0) begin
         bad++; $display("FAIL async_reset got=v:%b %h exp=v:0 0", out_valid_o, got); end
      exp_q.delete();
      in_valid_i = 0; out_ready_i = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
         bad++; $display("FAIL after_async got=r:%b v:%b exp=r:1 v:0", in_ready_o, out_valid_o); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         total++; if (out_valid_o !== (exp_q.size() != 0) || in_ready_o !== (exp_q.size() != 2)) begin
            bad++; $display("FAIL rnd_flags_%0d got=v:%b r:%b exp_count=%0d", n, out_valid_o, in_ready_o, exp_q.size()); end
         if (exp_q.size() != 0) begin
            total++; if (got !== exp_q[0]) begin bad++; $display("FAIL rnd_head_%0d got=%h exp=%h", n, got, exp_q[0]); end
         end
         drive(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom(), $urandom(),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      end
      idle(1'b1);
      idle(1'b1);
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_immediates();
      test_backpressure();
      test_branch_illegal();
      test_flush();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Decode-and-dispatch stage that sits in front of the 32-bit ALU. It accepts raw RV32I instructions plus register operand values over a valid/ready handshake. It decodes each instruction into the ALU operation code and the selected A/B operands, and presents them to the ALU from a 2-entry buffer. The buffer decouples the fetch/regfile side from the execute side and supports a synchronous flush for redirects.

## Interface
- `DEPTH`, 2: buffer entries. Fixed at 2; no other value is supported.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush_i`  in  1  synchronous flush; discards all buffered entries
- `in_valid_i`  in  1  instruction/operands valid
- `in_ready_o`  out  1  buffer can accept this cycle
- `instr_i`  in  32  RV32I instruction word
- `pc_i`  in  32  instruction address
- `rs1_i`, `rs2_i`  in  32  register operand values
- `out_valid_o`  out  1  head entry valid
- `out_ready_i`  in  1  ALU side consumes head entry
- `a_o`, `b_o`  out  32  ALU operands
- `alu_op_o`  out  4  ALU operation code
- `is_branch_o`  out  1  conditional branch; `funct3_o` selects the condition
- `funct3_o`  out  3  instr[14:12] of head entry
- `illegal_o`  out  1  unsupported encoding

## Operation
- **Op codes:** 0 SLL, 1 SRA, 2 SRL, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 11 SLT, 12 SLTU, 15 NOP/illegal.
- **OP (0110011), a=rs1, b=rs2:**
  - funct7=0000000: f3 000→5, 001→0, 010→11, 011→12, 100→9, 101→2, 110→8, 111→7.
  - funct7=0100000: f3 000→6, 101→1.
  - Any other funct7/funct3 combination: illegal.
- **OP-IMM (0010011), a=rs1, b=sign-extended instr[31:20]:**
  - Same funct3 mapping as OP; no SUB form.
  - Shifts (f3 001/101): b={27'b0,instr[24:20]}.
  - SLLI requires instr[31:25]=0000000.
  - f3 101: instr[31:25]=0000000→SRLI (2), 0100000→SRAI (1); any other value is illegal.
- **LUI (0110111):** a=0, b={instr[31:12],12'b0}, op 5.
- **AUIPC (0010111):** a=pc_i, b=U-immediate, op 5.
- **BRANCH (1100011):** a=rs1, b=rs2, op 6, is_branch=1. f3 010/011 are illegal.
- **Any other opcode:** illegal.
- **Illegal entries:** a=b=0, op 15, is_branch=0, illegal=1. They are still buffered and dispatched in order.
- **Buffer:** 2 entries with read pointer, write pointer and count (0..2).
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - in_ready_o = (count!=2).
  - out_valid_o = (count!=0).
  - Outputs are driven from the head entry.
- **Pointer/count update:**
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap 1→0.
- **Flush:**
  - flush_i=1 sets count and both pointers to 0.
  - Flush overrides push and pop in the same cycle; the input offered that cycle is dropped.
- **Reset:** count, pointers and all entry fields go to 0. After reset out_valid_o=0, in_ready_o=1, a_o=b_o=0, alu_op_o=0, funct3_o=0, is_branch_o=0, illegal_o=0.

## Timing
- **Latency:** 1 cycle. An instruction pushed at edge N appears on the outputs after edge N, with out_valid_o=1 in cycle N+1 when the buffer was empty.
- **Output paths:** all outputs come from registers or the head-entry mux. There is no combinational path from in_valid_i/instr_i to outputs.
- **in_ready_o:** depends only on count, not on out_ready_i in the same cycle.
- **Throughput:** sustained 1 instruction per cycle when out_ready_i is held high.
- **Full buffer:** with count=2, in_ready_o=0 even if a pop occurs in that cycle. The slot is visible the following cycle.
- **Stall stability:** head-entry outputs hold stable while out_valid_o=1 and out_ready_i=0.
- **Asynchronous reset:** rst_n low clears state immediately, mid-transfer included. Entries in flight are lost.

## Test plan
- **Reset and single ADD:**
  - Stimulus: release rst_n, push instr=0x003100B3 (add x1,x2,x3) with rs1=7, rs2=5.
  - Response: next cycle out_valid=1, a=7, b=5, alu_op=5, illegal=0.
- **Immediates:**
  - Push SRAI 0x4041D093 (srai x1,x3,4) with rs1=0x80000000 → alu_op=1, b=4.
  - Push ADDI with imm=-1 → b=0xFFFFFFFF.
  - Push LUI 0x123450B7 → a=0, b=0x12345000.
- **Backpressure:**
  - Stimulus: hold out_ready=0 and push 3 back-to-back instructions.
  - Response: first two accepted; in_ready=0 on the third; head outputs stable.
  - Then raise out_ready: dispatched in push order, third accepted one cycle after the first pop.
- **Branch and illegal:**
  - BEQ 0x00208463 → is_branch=1, funct3=0, alu_op=6.
  - Branch with f3=010 → illegal=1, alu_op=15.
  - Opcode 0x73 → illegal=1, a=b=0.
- **Flush:**
  - Stimulus: with count=2, assert flush_i together with a push and a pop.
  - Response: next cycle out_valid=0, in_ready=1; the pushed instruction is not dispatched.
- **Simultaneous push/pop with wrap and async reset:**
  - Stimulus: stream 6 instructions with out_ready=1 at count=1.
  - Response: count stays 1 and pointers wrap correctly.
  - Stimulus: drop rst_n mid-stream. Response: out_valid=0 immediately.
